// File: rtl/siphash_msg_ctrl.sv
// SipHash message sequencer: streams 64-bit words into siphash_core, builds the final length/padding block, folds the tag.
// Optional SIPHASH_MSG_CTRL_STATS_EN adds msg_count/block_count statistics outputs.
module siphash_msg_ctrl #(
  parameter logic [3:0] COMPRESSION_ROUNDS = 4'h2,
  parameter logic [3:0] FINAL_ROUNDS       = 4'h4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [127:0] key,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  in_data,
  input  logic [3:0]   in_bytes,
  input  logic         in_last,
  output logic         busy,
  output logic [63:0]  tag,
  output logic         tag_valid,
  output logic         core_initalize,
  output logic         core_compress,
  output logic         core_finalize,
  output logic         core_long,
  output logic [3:0]   core_compression_rounds,
  output logic [3:0]   core_final_rounds,
  output logic [127:0] core_key,
  output logic [63:0]  core_mi,
  input  logic         core_ready,
  input  logic [127:0] core_word,
  input  logic         core_word_valid
`ifdef SIPHASH_MSG_CTRL_STATS_EN
  ,
  output logic [31:0]  msg_count,
  output logic [31:0]  block_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ACCEPT,
    S_COMP_WAIT,
    S_PAD,
    S_PAD_WAIT,
    S_FINAL,
    S_FINAL_WAIT
  } state_t;

  state_t         state, state_nxt;
  logic [127:0]   key_reg, key_nxt;
  logic [7:0]     len_reg, len_nxt;
  logic           pad_pending, pad_nxt;
  logic           busy_nxt, tag_valid_nxt;
  logic [63:0]    tag_nxt;
  logic [3:0]     n_eff;
  logic [7:0]     len_add;
  logic           word_acc;
  logic           done;

  function automatic logic [3:0] sat_bytes(input logic [3:0] n);
    return (n > 4'd8) ? 4'd8 : n;
  endfunction

  function automatic logic [55:0] mask_bytes(input logic [55:0] d, input logic [3:0] n);
    logic [55:0] m;
    m = '0;
    for (int i = 0; i < 7; i++) begin
      if (i < int'(n)) m[8*i +: 8] = d[8*i +: 8];
    end
    return m;
  endfunction

  assign core_long               = 1'b0;
  assign core_compression_rounds = COMPRESSION_ROUNDS;
  assign core_final_rounds       = FINAL_ROUNDS;
  assign core_key                = key_reg;

  // Non-last words always count as a full 8 bytes, whatever in_bytes says.
  assign n_eff    = in_last ? sat_bytes(in_bytes) : 4'd8;
  assign len_add  = len_reg + {4'd0, n_eff};
  assign word_acc = (state == S_ACCEPT) && in_valid && core_ready;
  assign done     = (state == S_FINAL_WAIT) && core_ready && core_word_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      key_reg     <= '0;
      len_reg     <= '0;
      pad_pending <= 1'b0;
      busy        <= 1'b0;
      tag         <= '0;
      tag_valid   <= 1'b0;
    end else begin
      state       <= state_nxt;
      key_reg     <= key_nxt;
      len_reg     <= len_nxt;
      pad_pending <= pad_nxt;
      busy        <= busy_nxt;
      tag         <= tag_nxt;
      tag_valid   <= tag_valid_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    key_nxt        = key_reg;
    len_nxt        = len_reg;
    pad_nxt        = pad_pending;
    busy_nxt       = busy;
    tag_nxt        = tag;
    tag_valid_nxt  = tag_valid;
    in_ready       = 1'b0;
    core_initalize = 1'b0;
    core_compress  = 1'b0;
    core_finalize  = 1'b0;
    core_mi        = 64'h0;
    case (state)
      S_IDLE: begin
        if (start) begin
          key_nxt       = key;
          len_nxt       = 8'h0;
          pad_nxt       = 1'b0;
          tag_valid_nxt = 1'b0;
          busy_nxt      = 1'b1;
          state_nxt     = S_INIT;
        end
      end
      S_INIT: begin
        core_initalize = 1'b1;
        state_nxt      = S_ACCEPT;
      end
      S_ACCEPT: begin
        in_ready = core_ready;
        // A short last word carries the total length in its top byte.
        if (in_last && (n_eff < 4'd8)) core_mi = {len_add, mask_bytes(in_data[55:0], n_eff)};
        else                           core_mi = in_data;
        if (word_acc) begin
          if (in_last && (n_eff == 4'd0)) begin
            state_nxt = S_PAD;
          end else begin
            core_compress = 1'b1;
            len_nxt       = len_add;
            if (!in_last) begin
              state_nxt = S_COMP_WAIT;
            end else if (n_eff == 4'd8) begin
              pad_nxt   = 1'b1;
              state_nxt = S_COMP_WAIT;
            end else begin
              state_nxt = S_PAD_WAIT;
            end
          end
        end
      end
      S_COMP_WAIT: begin
        if (core_ready) state_nxt = pad_pending ? S_PAD : S_ACCEPT;
      end
      S_PAD: begin
        core_mi       = {len_reg, 56'h0};
        core_compress = 1'b1;
        pad_nxt       = 1'b0;
        state_nxt     = S_PAD_WAIT;
      end
      S_PAD_WAIT: begin
        if (core_ready) state_nxt = S_FINAL;
      end
      S_FINAL: begin
        core_finalize = 1'b1;
        state_nxt     = S_FINAL_WAIT;
      end
      S_FINAL_WAIT: begin
        if (done) begin
          tag_nxt       = core_word[127:64] ^ core_word[63:0];
          tag_valid_nxt = 1'b1;
          busy_nxt      = 1'b0;
          state_nxt     = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef SIPHASH_MSG_CTRL_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      msg_count   <= '0;
      block_count <= '0;
    end else begin
      if (done)          msg_count   <= msg_count + 32'd1;
      if (core_compress) block_count <= block_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/siphash_msg_ctrl.md
Name: siphash_msg_ctrl

Overview:
Message sequencer for siphash_core. Accepts a keyed message as a stream of 64-bit little-endian words with a valid/ready handshake. Drives the core's initalize/compress/finalize strobes, builds the SipHash final padding block (remaining bytes plus length byte), and folds the core's 128-bit output into the 64-bit SipHash tag. Sits between the host/bus wrapper and siphash_core.

Parameters:
COMPRESSION_ROUNDS, 4'h2, value driven on core_compression_rounds (c); must be 1..15.
FINAL_ROUNDS, 4'h4, value driven on core_final_rounds (d); must be 1..15.

Ports:
clk  in  1  clock; all logic on rising edge.
reset_n  in  1  asynchronous, active-low reset.
start  in  1  one-cycle pulse; latches key and begins a message. Ignored while busy=1.
key  in  128  k0=key[63:0], k1=key[127:64]; sampled only on an accepted start.
in_valid  in  1  in_data/in_bytes/in_last are valid.
in_ready  out  1  controller accepts a word this cycle when in_valid&in_ready.
in_data  in  64  message byte i at in_data[8i+7:8i].
in_bytes  in  4  valid bytes in a last word, 0..8; ignored when in_last=0 (word counts as 8); values >8 are treated as 8.
in_last  in  1  marks the final word of the message.
busy  out  1  high from the accepted start until tag_valid rises.
tag  out  64  SipHash result = core_word[127:64]^core_word[63:0].
tag_valid  out  1  high from completion until the next accepted start.
core_initalize, core_compress, core_finalize  out  1 each  one-cycle strobes to core.
core_long  out  1  tied 0.
core_compression_rounds, core_final_rounds  out  4 each  parameter values.
core_key  out  128  latched key.
core_mi  out  64  message/padding block for compress.
core_ready  in  1  core ready.
core_word  in  128  core output word.
core_word_valid  in  1  core output valid.

Behaviour:
- Reset: all outputs and strobes 0 except in_ready=0. busy=0, tag=0, tag_valid=0. len_reg=0, FSM=IDLE, key_reg=0.
- The core ready register falls the cycle after a compress/finalize strobe. WAIT states sample core_ready starting the cycle after the strobe.
- FSM states:
  - IDLE: on start, latch key, clear len_reg and tag_valid, set busy, go to INIT.
  - INIT: pulse core_initalize, go to ACCEPT.
  - ACCEPT: in_ready=1 only when core_ready=1. When a word is accepted:
    - in_last=0: core_mi=in_data, pulse core_compress, len_reg+=8, go to COMP_WAIT.
    - in_last=1 with n=in_bytes in 1..7: len_reg+=n; core_mi={len_new[7:0], in_data[55:0] masked to the low n bytes}; pulse compress; go to PAD_WAIT.
    - in_last=1 with n=8: compress in_data, len_reg+=8, go to COMP_WAIT with pad_pending=1.
    - in_last=1 with n=0: go to PAD.
  - COMP_WAIT: when core_ready=1, go to PAD if pad_pending, else ACCEPT.
  - PAD: core_mi={len_reg[7:0],56'h0}, pulse compress, clear pad_pending, go to PAD_WAIT.
  - PAD_WAIT: when core_ready=1, go to FINAL.
  - FINAL: pulse core_finalize, go to FINAL_WAIT.
  - FINAL_WAIT: when core_ready=1 and core_word_valid=1, register tag, set tag_valid=1, clear busy, go to IDLE.
- core_mi is combinational from the current word/state and is valid in the strobe cycle.
- len_reg is 8 bits and wraps mod 256, as SipHash requires.
- Exactly one compression per non-last word. A last word produces one or two compressions.
- Empty message: start, then a single last word with in_bytes=0 gives one pad block.
- start asserted while busy: ignored; no state change.
- in_valid held with in_ready=0: the word is held by the source; the controller does not consume it.
- Reset mid-message: immediate return to reset state; the core must be reset by the same reset_n.

Optional Feature:
SIPHASH_MSG_CTRL_STATS_EN:
- When defined: adds outputs msg_count[31:0] (+1 per tag_valid rise) and block_count[31:0] (+1 per core_compress strobe, including pad blocks). Both are cleared by reset only, and wrap at 2^32.
- When undefined: the ports and counters are absent.

Test Plan:
Key 0x0f0e0d0c0b0a09080706050403020100 is used in all scenarios; all expect c=2, d=4.
- Empty message (one last word, in_bytes=0) -> tag=0x726fdb47dd0e0e31; exactly 1 compress strobe.
- Bytes 00..07 as one last word, in_bytes=8 -> tag=0x93f5f5799a932462; 2 compress strobes (data + pad 0x0800000000000000).
- Bytes 00..0e as word 0x0706050403020100, then last word 0x000e0d0c0b0a0908 with in_bytes=7 -> tag=0xa129ca6149be45e5; pad core_mi=0x0f0e0d0c0b0a0908.
- Source holds in_valid with random stalls; pulse start during busy -> same tags as above; no duplicated or lost words; start ignored.
- 33 full words (264 bytes), last in_bytes=8 -> pad block top byte 0x08 (264 mod 256); tag matches the software model.
- Assert reset_n low during COMP_WAIT -> busy=0, tag_valid=0, in_ready=0 next cycle; a following empty message gives 0x726fdb47dd0e0e31.
